// File: rtl/updown_counter_mod_if.sv
// Command/status bundle for updown_counter_mod.
// master drives clear/set/load/load_value/cnt/up; slave returns counter/tc/wrap/load_err
// (plus tick when COUNTER_PRESCALE_EN is defined).
interface updown_counter_mod_if #(
   parameter int WIDTH = 4
);
   logic             clear;
   logic             set;
   logic             load;
   logic [WIDTH-1:0] load_value;
   logic             cnt;
   logic             up;
   logic [WIDTH-1:0] counter;
   logic             tc;
   logic             wrap;
   logic             load_err;
`ifdef COUNTER_PRESCALE_EN
   logic             tick;

   modport master (
      output clear, set, load, load_value, cnt, up,
      input  counter, tc, wrap, load_err, tick
   );
   modport slave (
      input  clear, set, load, load_value, cnt, up,
      output counter, tc, wrap, load_err, tick
   );
`else
   modport master (
      output clear, set, load, load_value, cnt, up,
      input  counter, tc, wrap, load_err
   );
   modport slave (
      input  clear, set, load, load_value, cnt, up,
      output counter, tc, wrap, load_err
   );
`endif
endinterface

// File: rtl/updown_counter_mod.sv
// Modulo-N up/down counter: sync clear/set/load, wrap or saturate policy.
// Ports: clock, reset_n (async low), bus (slave modport of updown_counter_mod_if).
// Optional macro COUNTER_PRESCALE_EN adds PRESCALE divider and bus.tick output.
module updown_counter_mod #(
   parameter int          WIDTH    = 4,
   parameter int unsigned MODULUS  = 16,
   parameter bit          SATURATE = 1'b0
`ifdef COUNTER_PRESCALE_EN
   ,
   parameter int unsigned PRESCALE = 4
`endif
) (
   input logic                 clock,
   input logic                 reset_n,
   updown_counter_mod_if.slave bus
);
   localparam logic [WIDTH-1:0] MAX  = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] ZERO = '0;

   logic [WIDTH-1:0] counter_q, counter_d;
   logic             wrap_q, wrap_d;
   logic             err_q, err_d;
   logic             adv;
   logic             at_end;
   logic             in_range;

   // Range test done at 32 bits so MODULUS = 2^WIDTH is handled.
   assign in_range = 32'(bus.load_value) < MODULUS;

   // at_end: counter sits at the boundary for the current direction.
   assign at_end = bus.up ? (counter_q == MAX) : (counter_q == ZERO);

`ifdef COUNTER_PRESCALE_EN
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

   logic [PW-1:0] pre_q, pre_d;
   logic          tick_q;
   logic          pre_end;

   assign pre_end = (pre_q == PMAX);
   assign adv     = bus.cnt & pre_end;

   always_comb begin
      pre_d = pre_q;
      if (bus.clear | bus.set | bus.load) begin
         pre_d = '0;
      end else if (bus.cnt) begin
         pre_d = pre_end ? '0 : pre_q + 1'b1;
      end
   end

   // Tick marks a counter update; clear/set/load take priority over it.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pre_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         pre_q  <= pre_d;
         tick_q <= adv & ~(bus.clear | bus.set | bus.load);
      end
   end

   assign bus.tick = tick_q;
   assign bus.tc   = reset_n & bus.cnt & pre_end & at_end;
`else
   assign adv    = bus.cnt;
   assign bus.tc = reset_n & bus.cnt & at_end;
`endif

   always_comb begin
      counter_d = counter_q;
      wrap_d    = 1'b0;
      err_d     = 1'b0;
      priority case (1'b1)
         bus.clear: counter_d = MAX;
         bus.set:   counter_d = ZERO;
         bus.load: begin
            if (in_range) counter_d = bus.load_value;
            else          err_d     = 1'b1;
         end
         adv: begin
            if (bus.up) begin
               if (counter_q != MAX) begin
                  counter_d = counter_q + 1'b1;
               end else if (!SATURATE) begin
                  counter_d = ZERO;
                  wrap_d    = 1'b1;
               end
            end else begin
               if (counter_q != ZERO) begin
                  counter_d = counter_q - 1'b1;
               end else if (!SATURATE) begin
                  counter_d = MAX;
                  wrap_d    = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         counter_q <= MAX;
         wrap_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         counter_q <= counter_d;
         wrap_q    <= wrap_d;
         err_q     <= err_d;
      end
   end

   assign bus.counter  = counter_q;
   assign bus.wrap     = wrap_q;
   assign bus.load_err = err_q;
endmodule

// File: tb/tb_updown_counter_mod.sv
// Directed bench for updown_counter_mod: defaults, MODULUS=10, SATURATE=1,
// and (with COUNTER_PRESCALE_EN) a PRESCALE=4 instance.
module tb_updown_counter_mod;
   logic clock = 1'b0;
   logic reset_n = 1'b0;
   int   vectors = 0;
   int   errors = 0;

   always #5 clock = ~clock;

   updown_counter_mod_if #(.WIDTH(4)) b0 ();
   updown_counter_mod_if #(.WIDTH(4)) b1 ();
   updown_counter_mod_if #(.WIDTH(4)) b2 ();

`ifdef COUNTER_PRESCALE_EN
   updown_counter_mod #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0), .PRESCALE(1))
      d0 (.clock(clock), .reset_n(reset_n), .bus(b0));
   updown_counter_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0), .PRESCALE(1))
      d1 (.clock(clock), .reset_n(reset_n), .bus(b1));
   updown_counter_mod #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b1), .PRESCALE(1))
      d2 (.clock(clock), .reset_n(reset_n), .bus(b2));
   updown_counter_mod_if #(.WIDTH(4)) b3 ();
   updown_counter_mod #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0), .PRESCALE(4))
      d3 (.clock(clock), .reset_n(reset_n), .bus(b3));
`else
   updown_counter_mod #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0))
      d0 (.clock(clock), .reset_n(reset_n), .bus(b0));
   updown_counter_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0))
      d1 (.clock(clock), .reset_n(reset_n), .bus(b1));
   updown_counter_mod #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b1))
      d2 (.clock(clock), .reset_n(reset_n), .bus(b2));
`endif

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_all();
      {b0.clear, b0.set, b0.load, b0.cnt, b0.up} = '0;
      {b1.clear, b1.set, b1.load, b1.cnt, b1.up} = '0;
      {b2.clear, b2.set, b2.load, b2.cnt, b2.up} = '0;
      b0.load_value = '0;
      b1.load_value = '0;
      b2.load_value = '0;
`ifdef COUNTER_PRESCALE_EN
      {b3.clear, b3.set, b3.load, b3.cnt, b3.up} = '0;
      b3.load_value = '0;
`endif
   endtask

   task automatic test_reset();
      idle_all();
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      step();
      b0.load = 1'b1;
      b0.load_value = 4'd3;
      step();
      b0.load = 1'b0;
      vectors++;
      if (b0.counter !== 4'd3) begin
         errors++;
         $display("FAIL reset_preload got=%h exp=3", b0.counter);
      end
      // Assert mid-cycle with cnt/up set so tc would be 1 if not gated.
      #2;
      b0.cnt = 1'b1;
      b0.up = 1'b1;
      reset_n = 1'b0;
      #1;
      vectors++;
      if (b0.counter !== 4'hF) begin
         errors++;
         $display("FAIL reset_async got=%h exp=F", b0.counter);
      end
      vectors++;
      if (b0.wrap !== 1'b0 || b0.load_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags wrap=%b err=%b exp=0/0", b0.wrap, b0.load_err);
      end
      vectors++;
      if (b0.tc !== 1'b0) begin
         errors++;
         $display("FAIL reset_tc got=%b exp=0", b0.tc);
      end
      vectors++;
      if (b1.counter !== 4'd9) begin
         errors++;
         $display("FAIL reset_mod10 got=%h exp=9", b1.counter);
      end
      idle_all();
      step();
      #2;
      reset_n = 1'b1;
      step();
      vectors++;
      if (b0.counter !== 4'hF) begin
         errors++;
         $display("FAIL reset_release got=%h exp=F", b0.counter);
      end
   endtask

   task automatic test_down_wrap();
      logic [3:0] e;
      logic       ew;
      int         wraps;
      e = 4'hF;
      wraps = 0;
      b0.up = 1'b0;
      b0.cnt = 1'b1;
      #1;
      for (int i = 0; i < 17; i++) begin
         vectors++;
         if (b0.counter !== e || b0.tc !== (e == 4'd0)) begin
            errors++;
            $display("FAIL down_step%0d cnt=%h tc=%b exp=%h/%b",
                     i, b0.counter, b0.tc, e, (e == 4'd0));
         end
         ew = (e == 4'd0);
         e = (e == 4'd0) ? 4'hF : e - 4'd1;
         step();
         if (b0.wrap === 1'b1) wraps++;
         vectors++;
         if (b0.wrap !== ew) begin
            errors++;
            $display("FAIL down_wrap%0d got=%b exp=%b", i, b0.wrap, ew);
         end
      end
      vectors++;
      if (wraps != 1) begin
         errors++;
         $display("FAIL down_wrap_count got=%0d exp=1", wraps);
      end
      b0.cnt = 1'b0;
      step();
   endtask

   task automatic test_modulus10();
      b1.set = 1'b1;
      step();
      b1.set = 1'b0;
      b1.up = 1'b1;
      b1.cnt = 1'b1;
      for (int i = 1; i <= 9; i++) begin
         step();
         vectors++;
         if (b1.counter !== 4'(i)) begin
            errors++;
            $display("FAIL mod10_up%0d got=%h exp=%h", i, b1.counter, 4'(i));
         end
      end
      vectors++;
      if (b1.tc !== 1'b1) begin
         errors++;
         $display("FAIL mod10_tc got=%b exp=1", b1.tc);
      end
      step();
      vectors++;
      if (b1.counter !== 4'd0 || b1.wrap !== 1'b1) begin
         errors++;
         $display("FAIL mod10_wrap cnt=%h wrap=%b exp=0/1", b1.counter, b1.wrap);
      end
      b1.cnt = 1'b0;
      b1.load = 1'b1;
      b1.load_value = 4'd12;
      step();
      vectors++;
      if (b1.counter !== 4'd0 || b1.load_err !== 1'b1 || b1.wrap !== 1'b0) begin
         errors++;
         $display("FAIL mod10_badload cnt=%h err=%b wrap=%b exp=0/1/0",
                  b1.counter, b1.load_err, b1.wrap);
      end
      b1.load_value = 4'd7;
      step();
      b1.load = 1'b0;
      vectors++;
      if (b1.counter !== 4'd7 || b1.load_err !== 1'b0) begin
         errors++;
         $display("FAIL mod10_load7 cnt=%h err=%b exp=7/0", b1.counter, b1.load_err);
      end
      step();
   endtask

   task automatic test_saturate();
      b2.set = 1'b1;
      step();
      b2.set = 1'b0;
      b2.up = 1'b0;
      b2.cnt = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         vectors++;
         if (b2.counter !== 4'd0 || b2.wrap !== 1'b0 || b2.tc !== 1'b1) begin
            errors++;
            $display("FAIL sat_low%0d cnt=%h wrap=%b tc=%b exp=0/0/1",
                     i, b2.counter, b2.wrap, b2.tc);
         end
      end
      b2.up = 1'b1;
      for (int i = 1; i <= 2; i++) begin
         step();
         vectors++;
         if (b2.counter !== 4'(i)) begin
            errors++;
            $display("FAIL sat_up%0d got=%h exp=%h", i, b2.counter, 4'(i));
         end
      end
      b2.cnt = 1'b0;
      b2.load = 1'b1;
      b2.load_value = 4'd14;
      step();
      b2.load = 1'b0;
      b2.cnt = 1'b1;
      step();
      step();
      vectors++;
      if (b2.counter !== 4'hF || b2.wrap !== 1'b0) begin
         errors++;
         $display("FAIL sat_high cnt=%h wrap=%b exp=F/0", b2.counter, b2.wrap);
      end
      b2.cnt = 1'b0;
      step();
   endtask

   task automatic test_priority();
      b0.load = 1'b1;
      b0.load_value = 4'd3;
      step();
      {b0.clear, b0.set, b0.load, b0.cnt, b0.up} = 5'b11111;
      b0.load_value = 4'd5;
      step();
      vectors++;
      if (b0.counter !== 4'hF) begin
         errors++;
         $display("FAIL prio_clear got=%h exp=F", b0.counter);
      end
      vectors++;
      if (b0.tc !== 1'b1) begin
         errors++;
         $display("FAIL prio_tc got=%b exp=1", b0.tc);
      end
      {b0.clear, b0.set, b0.load, b0.cnt} = 4'b0110;
      step();
      vectors++;
      if (b0.counter !== 4'd0) begin
         errors++;
         $display("FAIL prio_set got=%h exp=0", b0.counter);
      end
      {b0.clear, b0.set, b0.load, b0.cnt} = 4'b0011;
      step();
      vectors++;
      if (b0.counter !== 4'd5 || b0.wrap !== 1'b0) begin
         errors++;
         $display("FAIL prio_load cnt=%h wrap=%b exp=5/0", b0.counter, b0.wrap);
      end
      idle_all();
      step();
      vectors++;
      if (b0.counter !== 4'd5) begin
         errors++;
         $display("FAIL prio_idle got=%h exp=5", b0.counter);
      end
   endtask

`ifdef COUNTER_PRESCALE_EN
   task automatic test_prescale();
      int ticks;
      ticks = 0;
      b3.set = 1'b1;
      step();
      b3.set = 1'b0;
      b3.up = 1'b1;
      b3.cnt = 1'b1;
      for (int i = 0; i < 12; i++) begin
         step();
         if (b3.tick === 1'b1) ticks++;
      end
      vectors++;
      if (b3.counter !== 4'd3 || ticks != 3) begin
         errors++;
         $display("FAIL pre_count cnt=%h ticks=%0d exp=3/3", b3.counter, ticks);
      end
      step();
      b3.load = 1'b1;
      b3.load_value = 4'd0;
      step();
      b3.load = 1'b0;
      step();
      step();
      step();
      vectors++;
      if (b3.counter !== 4'd0) begin
         errors++;
         $display("FAIL pre_reload3 got=%h exp=0", b3.counter);
      end
      step();
      vectors++;
      if (b3.counter !== 4'd1 || b3.tick !== 1'b1) begin
         errors++;
         $display("FAIL pre_reload4 cnt=%h tick=%b exp=1/1", b3.counter, b3.tick);
      end
      b3.cnt = 1'b0;
      step();
   endtask
`endif

   initial begin
      test_reset();
      test_down_wrap();
      test_modulus10();
      test_saturate();
      test_priority();
`ifdef COUNTER_PRESCALE_EN
      test_prescale();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule

// File: doc/updown_counter_mod.md
Name: updown_counter_mod

Overview:
Parametrised modulo-N up/down counter with synchronous clear, set and parallel load, and a selectable wrap or saturate policy. It generalises the team's fixed 4-bit down counter. It adds width, modulus, direction control, terminal-count and wrap indications, and load-range checking. Typical use is timers, event counters and address sequencers in lab designs.

Parameters:
WIDTH, 4, counter width in bits; legal range 2..16.
MODULUS, 16, count range is 0..MODULUS-1; must satisfy 2 <= MODULUS <= 2^WIDTH.
SATURATE, 0, 0 = wrap at range ends; 1 = hold at range ends.

Ports:
clock  in  1  rising-edge clock.
reset_n  in  1  asynchronous active-low reset.
clear  in  1  synchronous; counter <= MODULUS-1.
set  in  1  synchronous; counter <= 0.
load  in  1  synchronous; counter <= load_value if in range.
load_value  in  WIDTH  parallel load data.
cnt  in  1  count enable.
up  in  1  direction: 1 = increment, 0 = decrement.
counter  out  WIDTH  registered count value.
tc  out  1  combinational terminal count.
wrap  out  1  registered one-cycle pulse.
load_err  out  1  registered one-cycle pulse.

Behaviour:
- Reset (reset_n = 0, asynchronous, any time):
  - counter = MODULUS-1; with the defaults this is 4'b1111.
  - wrap = 0, load_err = 0.
  - Release is synchronous to the next rising edge.
- Command priority per rising edge: clear > set > load > cnt. Exactly one action is taken per cycle.
- clear: counter <= MODULUS-1. wrap <= 0, load_err <= 0.
- set: counter <= 0. wrap <= 0, load_err <= 0.
- load:
  - If load_value < MODULUS: counter <= load_value, load_err <= 0.
  - Otherwise: counter unchanged, load_err <= 1 for one cycle.
  - wrap <= 0 in both cases.
- cnt with up = 1:
  - counter < MODULUS-1: counter + 1.
  - counter = MODULUS-1: goes to 0 if SATURATE = 0 (wrap <= 1); holds if SATURATE = 1 (wrap <= 0).
- cnt with up = 0:
  - counter > 0: counter - 1.
  - counter = 0: goes to MODULUS-1 if SATURATE = 0 (wrap <= 1); holds if SATURATE = 1.
- Idle (no command): counter holds; wrap <= 0, load_err <= 0.
- tc = cnt & ((up & counter == MODULUS-1) | (~up & counter == 0)).
  - tc is asserted regardless of clear/set/load in the same cycle.
  - tc is forced to 0 while reset_n = 0.
- Arithmetic is modulo MODULUS, never modulo 2^WIDTH. For non-power-of-two MODULUS, counter never takes a value >= MODULUS.
- Direction may change on any cycle. It takes effect on the same edge as cnt, with no pipeline latency.
- Latency: one clock from command to counter update. wrap and load_err appear in the same cycle as the updated counter.

Optional Feature:
Macro COUNTER_PRESCALE_EN.
- Defined:
  - Adds parameter PRESCALE (default 4, >= 1) and an internal prescale counter.
  - The counter advances only on every PRESCALE-th cycle with cnt = 1.
  - The prescaler advances only when cnt = 1 and resets to 0 on reset_n, clear, set or load.
  - tc additionally requires the prescaler to be at PRESCALE-1.
  - Adds output tick (1 bit): high in the cycles where the counter actually advances.
- Undefined: no prescaler and no tick port; the counter advances on every cnt cycle.

Test Plan:
1. Defaults; pulse reset_n low mid-cycle, then release -> counter = 4'hF immediately (asynchronous), wrap = 0, load_err = 0.
2. Defaults, up = 0, cnt = 1 for 17 cycles from 4'hF:
   - counter steps F, E, ..., 0, then F.
   - tc = 1 while counter = 0.
   - wrap pulses exactly once, in the cycle counter shows F.
3. MODULUS = 10, WIDTH = 4, up = 1, from 0: after 9 cnt cycles counter = 9 with tc = 1; the next cnt gives counter = 0 and wrap = 1. Load 4'd12 -> counter unchanged, load_err = 1 for one cycle. Load 4'd7 -> counter = 7.
4. SATURATE = 1, defaults: at counter = 0 with up = 0, cnt held for 3 cycles -> counter stays 0, wrap stays 0, tc = 1. Switch up = 1 -> counter 1, 2, ...
5. Simultaneous commands:
   - clear = set = load = cnt = 1 -> counter = MODULUS-1.
   - set = load = 1 with load_value = 5 -> counter = 0.
   - load = cnt = 1 with load_value = 5 -> counter = 5, no count applied.
6. COUNTER_PRESCALE_EN, PRESCALE = 4, defaults, up = 1, from 0:
   - 12 cnt cycles -> counter = 3, tick pulses exactly 3 times.
   - A load mid-sequence restarts the prescaler: the next advance occurs 4 cnt cycles after the load.
